// File: rtl/ycbcr422_to_rgb444_if.sv
// Pixel bundle for ycbcr422_to_rgb444: 4:2:2 YC stream in, RGB 4:4:4 stream out.
// The converter takes the slave side; a pixel source or bench takes the master side.
interface ycbcr422_to_rgb444_if;
    logic [15:0] yc_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [23:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;

    modport master (
        output yc_in, hsync_in, vsync_in, de_in,
        input  rgb_out, hsync_out, vsync_out, de_out
    );

    modport slave (
        input  yc_in, hsync_in, vsync_in, de_in,
        output rgb_out, hsync_out, vsync_out, de_out
    );
endinterface

// File: rtl/ycbcr422_to_rgb444.sv
// YCbCr 4:2:2 (BT.601 limited range) to 24-bit RGB with chroma re-pairing and clamping.
// Optional macro CHROMA_INTERP_EN: pixel 1 of a pair averages chroma with the next pair, latency 6.
module ycbcr422_to_rgb444 #(
    parameter bit YC_SWAP  = 1'b0,
    parameter bit CB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    ycbcr422_to_rgb444_if.slave vid
);
`ifdef CHROMA_INTERP_EN
    localparam int LOOK = 2;
`else
    localparam int LOOK = 0;
`endif
    localparam int NW  = LOOK + 1;
    localparam int LAT = LOOK + 4;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] c;
        logic       de;
        logic       ph;
    } smp_t;

    logic [7:0] w_y_in;
    logic [7:0] w_c_in;
    assign w_y_in = YC_SWAP ? vid.yc_in[7:0]  : vid.yc_in[15:8];
    assign w_c_in = YC_SWAP ? vid.yc_in[15:8] : vid.yc_in[7:0];

    // r_win[NW] is the pixel being paired; lower indices (and the live input) are newer samples.
    smp_t       r_win [1:NW];
    logic       r_phase;
    logic [7:0] r_c_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= 1'b0;
            r_c_prev <= '0;
            for (int i = 1; i <= NW; i++) r_win[i] <= '0;
        end else begin
            r_phase  <= vid.de_in ? ~r_phase : 1'b0;
            r_win[1] <= '{y: w_y_in, c: w_c_in, de: vid.de_in, ph: vid.de_in & r_phase};
            for (int i = 2; i <= NW; i++) r_win[i] <= r_win[i-1];
            r_c_prev <= r_win[NW].c;
        end
    end

    smp_t       w_cur;
    logic [7:0] w_l1_c;
    logic       w_l1_de;
    assign w_cur = r_win[NW];
`ifdef CHROMA_INTERP_EN
    logic [7:0] w_l2_c;
    logic       w_l2_de;
    assign w_l1_c  = r_win[NW-1].c;
    assign w_l1_de = r_win[NW-1].de;
    assign w_l2_c  = r_win[NW-2].c;
    assign w_l2_de = r_win[NW-2].de;
`else
    assign w_l1_c  = w_c_in;
    assign w_l1_de = vid.de_in;
`endif

    // Chroma of the current pair; an unpaired last pixel gets 128 for the missing sample.
    logic [7:0] w_c_first;
    logic [7:0] w_c_second;
    always_comb begin
        w_c_first  = w_cur.c;
        w_c_second = 8'd128;
        if (w_cur.ph) begin
            w_c_first  = r_c_prev;
            w_c_second = w_cur.c;
        end else if (w_l1_de) begin
            w_c_second = w_l1_c;
        end
    end

    logic [7:0] w_p_first;
    logic [7:0] w_p_second;
`ifdef CHROMA_INTERP_EN
    // Next pair's chroma; the last pair of a line falls back to its own (replication).
    logic [7:0] w_n_first;
    logic [7:0] w_n_second;
    always_comb begin
        w_n_first  = w_c_first;
        w_n_second = w_c_second;
        if (w_l1_de) begin
            w_n_first  = w_l1_c;
            w_n_second = w_l2_de ? w_l2_c : 8'd128;
        end
        w_p_first  = w_c_first;
        w_p_second = w_c_second;
        if (w_cur.ph) begin
            w_p_first  = 8'((9'(w_c_first)  + 9'(w_n_first)  + 9'd1) >> 1);
            w_p_second = 8'((9'(w_c_second) + 9'(w_n_second) + 9'd1) >> 1);
        end
    end
`else
    assign w_p_first  = w_c_first;
    assign w_p_second = w_c_second;
`endif

    logic [7:0] r_s1_y;
    logic [7:0] r_s1_cb;
    logic [7:0] r_s1_cr;
    logic       r_s1_de;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_y  <= '0;
            r_s1_cb <= '0;
            r_s1_cr <= '0;
            r_s1_de <= 1'b0;
        end else begin
            r_s1_y  <= w_cur.y;
            r_s1_cb <= CB_FIRST ? w_p_first  : w_p_second;
            r_s1_cr <= CB_FIRST ? w_p_second : w_p_first;
            r_s1_de <= w_cur.de;
        end
    end

    logic signed [8:0] w_yd;
    logic signed [8:0] w_cbd;
    logic signed [8:0] w_crd;
    assign w_yd  = $signed({1'b0, r_s1_y})  - 9'sd16;
    assign w_cbd = $signed({1'b0, r_s1_cb}) - 9'sd128;
    assign w_crd = $signed({1'b0, r_s1_cr}) - 9'sd128;

    logic signed [17:0] r_p_y;
    logic signed [17:0] r_p_r_cr;
    logic signed [17:0] r_p_g_cb;
    logic signed [17:0] r_p_g_cr;
    logic signed [17:0] r_p_b_cb;
    logic               r_s2_de;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_y    <= '0;
            r_p_r_cr <= '0;
            r_p_g_cb <= '0;
            r_p_g_cr <= '0;
            r_p_b_cb <= '0;
            r_s2_de  <= 1'b0;
        end else begin
            r_p_y    <= 18'(w_yd)  * 18'sd298;
            r_p_r_cr <= 18'(w_crd) * 18'sd409;
            r_p_g_cb <= 18'(w_cbd) * 18'sd100;
            r_p_g_cr <= 18'(w_crd) * 18'sd208;
            r_p_b_cb <= 18'(w_cbd) * 18'sd516;
            r_s2_de  <= r_s1_de;
        end
    end

    // Sums can exceed the 18-bit product range (e.g. B at full scale), hence 20 bits.
    logic signed [19:0] w_r_sum;
    logic signed [19:0] w_g_sum;
    logic signed [19:0] w_b_sum;
    assign w_r_sum = 20'(r_p_y) + 20'(r_p_r_cr) + 20'sd128;
    assign w_g_sum = 20'(r_p_y) - 20'(r_p_g_cb) - 20'(r_p_g_cr) + 20'sd128;
    assign w_b_sum = 20'(r_p_y) + 20'(r_p_b_cb) + 20'sd128;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        logic signed [19:0] s;
        s = v >>> 8;
        if (s < 20'sd0)
            return 8'd0;
        else if (s > 20'sd255)
            return 8'd255;
        else
            return s[7:0];
    endfunction

    logic [23:0]    r_rgb;
    logic           r_de_out;
    logic [LAT-1:0] r_hs_sr;
    logic [LAT-1:0] r_vs_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb    <= '0;
            r_de_out <= 1'b0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
        end else begin
            r_rgb    <= r_s2_de ? {clamp8(w_r_sum), clamp8(w_g_sum), clamp8(w_b_sum)} : 24'd0;
            r_de_out <= r_s2_de;
            r_hs_sr  <= {r_hs_sr[LAT-2:0], vid.hsync_in};
            r_vs_sr  <= {r_vs_sr[LAT-2:0], vid.vsync_in};
        end
    end

    assign vid.rgb_out   = r_rgb;
    assign vid.de_out    = r_de_out;
    assign vid.hsync_out = r_hs_sr[LAT-1];
    assign vid.vsync_out = r_vs_sr[LAT-1];
endmodule
